// File: rtl/aes_block_serializer.sv
// -----------------------------------------------------------------------------
// aes_block_serializer
//   Captures 128-bit AES result blocks into a small block FIFO and streams each
//   block out as WORD_W-bit words, most-significant word first, over a
//   valid/ready handshake. Words of one block are always contiguous, and a
//   following block is reloaded on the final handshake so there is no bubble.
//
// Ports
//   clk         in   1                system clock, rising edge
//   rst         in   1                synchronous active-high reset
//   blk_in      in   128              block from the AES core
//   blk_valid   in   1                blk_in holds a block to capture
//   blk_ready   out  1                FIFO can accept a block this cycle
//   word_out    out  WORD_W           current output word
//   word_valid  out  1                word_out is valid
//   word_ready  in   1                sink accepts word_out
//   word_last   out  1                word_out is the last word of its block
//   fill_level  out  $clog2(DEPTH)+1  blocks held in the FIFO (shifter excluded)
//
// State   | meaning
// --------+----------------------------------------------------------
// S_EMPTY | shifter idle; loads the FIFO head as soon as one is held
// S_SHIFT | shifter presenting word idx_q of the loaded block
// -----------------------------------------------------------------------------
module aes_block_serializer #(
   parameter int DEPTH  = 2,
   parameter int WORD_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [127:0]             blk_in,
   input  logic                     blk_valid,
   output logic                     blk_ready,
   output logic [WORD_W-1:0]        word_out,
   output logic                     word_valid,
   input  logic                     word_ready,
   output logic                     word_last,
   output logic [$clog2(DEPTH):0]   fill_level
);

   localparam int NW = 128 / WORD_W;
   localparam int IW = (NW > 1) ? $clog2(NW) : 1;
   localparam int PW = $clog2(DEPTH);
   localparam int FW = $clog2(DEPTH) + 1;
   localparam logic [FW-1:0] DEPTH_L  = FW'(DEPTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

   typedef enum logic {S_EMPTY, S_SHIFT} state_t;

   state_t          state_q, state_d;
   logic [127:0]    mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [FW-1:0]   fill_q, fill_d;
   logic [127:0]    shreg_q, shreg_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            push, pop;

   // Ready deliberately ignores a same-cycle pop: no pass-through when full.
   assign blk_ready  = !rst && (fill_q < DEPTH_L);
   assign push       = blk_valid && blk_ready;
   assign fill_level = fill_q;

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      idx_d      = idx_q;
      pop        = 1'b0;
      word_valid = 1'b0;
      word_last  = 1'b0;
      word_out   = '0;
      case (state_q)
         S_EMPTY: begin
            if (fill_q != '0) begin
               pop     = 1'b1;
               shreg_d = mem_q[rd_ptr_q];
               idx_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            word_valid = 1'b1;
            // The shifter moves the current word to the top, so the top slice
            // is always block[127 - idx*WORD_W -: WORD_W].
            word_out   = shreg_q[127 -: WORD_W];
            word_last  = (idx_q == LAST_IDX);
            if (word_ready) begin
               if (idx_q == LAST_IDX) begin
                  if (fill_q != '0) begin
                     pop     = 1'b1;
                     shreg_d = mem_q[rd_ptr_q];
                     idx_d   = '0;
                  end else begin
                     shreg_d = '0;
                     idx_d   = '0;
                     state_d = S_EMPTY;
                  end
               end else begin
                  idx_d   = idx_q + 1'b1;
                  shreg_d = shreg_q << WORD_W;
               end
            end
         end
         default: state_d = S_EMPTY;
      endcase
   end

   always_comb begin
      fill_d = fill_q;
      case ({push, pop})
         2'b10:   fill_d = fill_q + 1'b1;
         2'b01:   fill_d = fill_q - 1'b1;
         default: fill_d = fill_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= blk_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_EMPTY;
         shreg_q  <= '0;
         idx_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
         fill_q  <= fill_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_aes_block_serializer.sv
// -----------------------------------------------------------------------------
// tb_aes_block_serializer
//   Directed bench for aes_block_serializer: a 32-bit-word instance with a
//   two-entry FIFO and an 8-bit-word instance. Expected words are written out
//   by hand from the block constants.
// -----------------------------------------------------------------------------
module tb_aes_block_serializer;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] blk_in;
   logic         blk_valid;
   logic         blk_ready;
   logic [31:0]  word_out;
   logic         word_valid;
   logic         word_ready;
   logic         word_last;
   logic [1:0]   fill_level;

   logic [127:0] blk_in8;
   logic         blk_valid8;
   logic         blk_ready8;
   logic [7:0]   word_out8;
   logic         word_valid8;
   logic         word_ready8;
   logic         word_last8;
   logic [1:0]   fill_level8;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   aes_block_serializer #(.DEPTH(2), .WORD_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .blk_in     (blk_in),
      .blk_valid  (blk_valid),
      .blk_ready  (blk_ready),
      .word_out   (word_out),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .word_last  (word_last),
      .fill_level (fill_level)
   );

   aes_block_serializer #(.DEPTH(2), .WORD_W(8)) dut8 (
      .clk        (clk),
      .rst        (rst),
      .blk_in     (blk_in8),
      .blk_valid  (blk_valid8),
      .blk_ready  (blk_ready8),
      .word_out   (word_out8),
      .word_valid (word_valid8),
      .word_ready (word_ready8),
      .word_last  (word_last8),
      .fill_level (fill_level8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   localparam logic [127:0] BLK1 = 128'hc2f45dfa_8acd3f4d_a3dcfe8a_93cefa0a;
   localparam logic [127:0] BA   = 128'h00010203_04050607_08090a0b_0c0d0e0f;
   localparam logic [127:0] BB   = 128'h10111213_14151617_18191a1b_1c1d1e1f;
   localparam logic [127:0] BC   = 128'h20212223_24252627_28292a2b_2c2d2e2f;
   localparam logic [127:0] BD   = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
   localparam logic [127:0] B8   = 128'h00112233_44556677_8899aabb_ccddeeff;

   logic [31:0] exp_w [12];
   logic [31:0] b1_w  [4];

   initial begin
      b1_w = '{32'hc2f45dfa, 32'h8acd3f4d, 32'ha3dcfe8a, 32'h93cefa0a};
      exp_w = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
                32'h10111213, 32'h14151617, 32'h18191a1b, 32'h1c1d1e1f,
                32'h20212223, 32'h24252627, 32'h28292a2b, 32'h2c2d2e2f};

      rst = 1'b1; blk_in = '0; blk_valid = 1'b0; word_ready = 1'b0;
      blk_in8 = '0; blk_valid8 = 1'b0; word_ready8 = 1'b1;

      // ---- reset state
      tick(); tick();
      chk("rst_word_valid", 128'(word_valid), 128'(1'b0));
      chk("rst_word_last",  128'(word_last),  128'(1'b0));
      chk("rst_word_out",   128'(word_out),   128'h0);
      chk("rst_fill",       128'(fill_level), 128'h0);
      chk("rst_blk_ready",  128'(blk_ready),  128'(1'b0));
      rst = 1'b0;
      tick();
      chk("idle_blk_ready", 128'(blk_ready), 128'(1'b1));

      // ---- test 1: single block, sink always ready
      word_ready = 1'b1;
      blk_in = BLK1; blk_valid = 1'b1;
      tick();
      blk_valid = 1'b0;
      chk("t1_valid_after_push", 128'(word_valid), 128'(1'b0));
      chk("t1_fill_after_push",  128'(fill_level), 128'h1);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("t1_valid", 128'(word_valid), 128'(1'b1));
         chk("t1_word",  128'(word_out),   128'(b1_w[i]));
         chk("t1_last",  128'(word_last),  128'(i == 3));
         tick();
      end
      chk("t1_valid_drop", 128'(word_valid), 128'(1'b0));

      // ---- test 2: back-pressure on word 2
      blk_in = BLK1; blk_valid = 1'b1;
      tick();
      blk_valid = 1'b0;
      tick();
      chk("t2_w0", 128'(word_out), 128'(b1_w[0]));
      tick();
      chk("t2_w1", 128'(word_out), 128'(b1_w[1]));
      tick();
      chk("t2_w2", 128'(word_out), 128'(b1_w[2]));
      word_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t2_hold_word",  128'(word_out),   128'(b1_w[2]));
         chk("t2_hold_valid", 128'(word_valid), 128'(1'b1));
         chk("t2_hold_last",  128'(word_last),  128'(1'b0));
      end
      word_ready = 1'b1;
      tick();
      chk("t2_w3",      128'(word_out),  128'(b1_w[3]));
      chk("t2_w3_last", 128'(word_last), 128'(1'b1));
      tick();
      chk("t2_valid_drop", 128'(word_valid), 128'(1'b0));

      // ---- test 3: fill the FIFO with the sink stalled
      word_ready = 1'b0;
      blk_valid = 1'b1; blk_in = BA;
      tick();
      blk_in = BB;
      tick();
      blk_in = BC;
      tick();
      chk("t3_fill_full",  128'(fill_level), 128'h2);
      chk("t3_ready_full", 128'(blk_ready),  128'(1'b0));
      chk("t3_shifter_A",  128'(word_out),   128'(exp_w[0]));
      chk("t3_valid",      128'(word_valid), 128'(1'b1));
      blk_in = BD;
      tick();
      chk("t3_fill_no_4th", 128'(fill_level), 128'h2);
      blk_valid = 1'b0;
      word_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         chk("t3_valid",    128'(word_valid), 128'(1'b1));
         chk("t3_word",     128'(word_out),   128'(exp_w[i]));
         chk("t3_last",     128'(word_last),  128'((i % 4) == 3));
         chk("t3_fill_max", 128'(fill_level <= 2'd2), 128'(1'b1));
         tick();
      end
      chk("t3_no_4th_block", 128'(word_valid), 128'(1'b0));
      chk("t3_fill_empty",   128'(fill_level), 128'h0);

      // ---- test 4: back-to-back blocks, no bubble between them
      blk_valid = 1'b1; blk_in = BA;
      tick();
      blk_in = BB;
      tick();
      blk_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("t4_valid", 128'(word_valid), 128'(1'b1));
         chk("t4_word",  128'(word_out),   128'(exp_w[i]));
         chk("t4_last",  128'(word_last),  128'((i % 4) == 3));
         tick();
      end
      chk("t4_valid_drop", 128'(word_valid), 128'(1'b0));

      // ---- test 5: reset in the middle of a block with another queued
      blk_valid = 1'b1; blk_in = BA;
      tick();
      blk_in = BB;
      tick();
      blk_valid = 1'b0;
      chk("t5_w0", 128'(word_out), 128'(exp_w[0]));
      tick();
      chk("t5_w1",   128'(word_out),   128'(exp_w[1]));
      chk("t5_fill", 128'(fill_level), 128'h1);
      rst = 1'b1;
      #1;
      chk("t5_ready_in_rst", 128'(blk_ready), 128'(1'b0));
      tick();
      rst = 1'b0;
      #1;
      chk("t5_valid_cleared", 128'(word_valid), 128'(1'b0));
      chk("t5_fill_cleared",  128'(fill_level), 128'h0);
      chk("t5_ready",         128'(blk_ready),  128'(1'b1));
      chk("t5_word_cleared",  128'(word_out),   128'h0);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("t5_no_stale", 128'(word_valid), 128'(1'b0));
      end

      // ---- test 6: 8-bit words
      blk_in8 = B8; blk_valid8 = 1'b1;
      tick();
      blk_valid8 = 1'b0;
      chk("t6_valid_after_push", 128'(word_valid8), 128'(1'b0));
      tick();
      for (int i = 0; i < 16; i++) begin
         chk("t6_valid", 128'(word_valid8), 128'(1'b1));
         chk("t6_byte",  128'(word_out8),   128'(8'(i * 8'h11)));
         chk("t6_last",  128'(word_last8),  128'(i == 15));
         tick();
      end
      chk("t6_valid_drop", 128'(word_valid8), 128'(1'b0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
